clk_period_meter: RTL and testbench
===================================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the measurement counters and results.
REQ-002 SHALL have parameter TIMEOUT, default 32'd400_000_000: the watchdog limit in clk cycles, with 2 <= TIMEOUT <= 2^CNT_W-1.
REQ-003 SHALL have port clk, input, width 1: the single system clock, rising-edge active.
REQ-004 SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-005 SHALL have port sig_in, input, width 1: the signal under measurement, asynchronous to clk.
REQ-006 SHALL have port start, input, width 1: a one-cycle request to begin a measurement.
REQ-007 SHALL have port busy, output, width 1: high while in ARM or MEASURE.
REQ-008 SHALL have port valid, output, width 1: result valid, high only in DONE.
REQ-009 SHALL have port period, output, width CNT_W: clk cycles from one sig_in rising edge to the next.
REQ-010 SHALL have port high_time, output, width CNT_W: clk cycles from that rising edge to the following falling edge.
REQ-011 SHALL have port timeout, output, width 1: high when the measurement was aborted by the watchdog.

Function
REQ-012 SHALL pass sig_in through a 2-flop synchronizer, then a registered edge detector: rise = s & ~s_prev, fall = ~s & s_prev. Latency from a sig_in change to rise/fall is 3 clk cycles.
REQ-013 SHALL use an FSM with states IDLE, ARM, MEASURE, DONE.
REQ-014 In IDLE or DONE, start SHALL move the FSM to ARM next cycle, clear valid, clear timeout and clear the watchdog.
REQ-015 start SHALL be ignored while in ARM or MEASURE.
REQ-016 In ARM, rise SHALL move the FSM to MEASURE and load cnt <= 1. sig_in already high at start SHALL NOT count as an edge.
REQ-017 In MEASURE, each cycle without rise SHALL do cnt <= cnt+1. On fall, high_time SHALL latch cnt, first fall only. On rise, period SHALL latch cnt and the FSM SHALL go to DONE.
REQ-018 Result: a sig_in with period N and high time H cycles SHALL give period = N and high_time = H.
REQ-019 The watchdog SHALL count every cycle in ARM or MEASURE. When it reaches TIMEOUT-1, the FSM SHALL go to DONE next cycle with timeout=1, period=0 and high_time=0.
REQ-020 If rise and the watchdog limit occur in the same cycle, rise SHALL win (normal completion, timeout=0).
REQ-021 DONE SHALL hold valid=1 and all results stable until start or reset.
REQ-022 Outputs SHALL be registered, with no combinational path from start or sig_in to any output.
REQ-023 cnt SHALL never wrap; this is guaranteed by the TIMEOUT bound in REQ-002.

Reset
REQ-024 When reset is high at a clk edge, the FSM SHALL go to IDLE and busy, valid, timeout, period, high_time, cnt, the watchdog and the synchronizer/edge flops SHALL all go to 0.
REQ-025 Reset SHALL take priority over start and over any edge, including when asserted mid-ARM or mid-MEASURE.
REQ-026 No initial blocks SHALL be used; reset alone defines the starting state.

Structure
REQ-027 Shared package clk_meas_pkg SHALL hold the state encoding (IDLE=0, ARM=1, MEASURE=2, DONE=3) and the default CNT_W/TIMEOUT constants.
REQ-028 One sub-module, sync_edge, SHALL contain the synchronizer and edge detector. Its ports SHALL be clk, reset, async_in, rise, fall and level.
REQ-029 The top level SHALL contain the FSM, the counters and the output registers only.

Verification (bench uses CNT_W=8, TIMEOUT=64)
REQ-030 Square wave of period 10, high 4, then a start pulse -> valid=1, period=10, high_time=4, timeout=0, busy=0.
REQ-031 sig_in driven by Divider with DIV_FACTOR=3 on the same clk -> period=6, high_time=3.
REQ-032 sig_in held at 0, start pulse -> timeout=1, valid=1, period=0 exactly 65 cycles after start.
REQ-033 reset pulsed for 1 cycle mid-MEASURE -> next cycle busy=0, valid=0, period=0; a later start measures correctly.
REQ-034 start pulsed in ARM -> ignored, measurement unaffected. start in DONE -> valid=0 next cycle and re-arm.
REQ-035 sig_in high when start is pulsed -> no capture until a full low-to-high transition; result equals the true period.

Source files
------------

// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock-period meter: FSM encoding and default sizing.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meas_state_e;

  localparam int unsigned     CNT_W_DEF   = 32;
  localparam longint unsigned TIMEOUT_DEF = 64'd400_000_000;

endpackage

// File: rtl/clk_period_meter_sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic meta;
  logic sync;
  logic sync_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta      <= 1'b0;
      sync      <= 1'b0;
      sync_prev <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      meta      <= async_in;
      sync      <= meta;
      sync_prev <= sync;
      rise      <= sync & ~sync_prev;
      fall      <= ~sync & sync_prev;
    end
  end

  assign level = sync_prev;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of sig_in in clk cycles, with a watchdog abort.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned     CNT_W   = CNT_W_DEF,
  parameter longint unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  meas_state_e      state, next_state;
  logic             rise, fall, unused_level;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wd;
  logic             fall_seen;
  logic             wd_hit;

  sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .rise     (rise),
    .fall     (fall),
    .level    (unused_level)
  );

  assign wd_hit = (wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Rise is tested before the watchdog so a coincident edge completes normally.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = ARM;
      ARM: begin
        if (rise)        next_state = MEASURE;
        else if (wd_hit) next_state = DONE;
      end
      MEASURE: begin
        if (rise)        next_state = DONE;
        else if (wd_hit) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      period    <= '0;
      high_time <= '0;
      cnt       <= '0;
      wd        <= '0;
      fall_seen <= 1'b0;
    end else begin
      busy  <= (next_state == ARM) || (next_state == MEASURE);
      valid <= (next_state == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            timeout   <= 1'b0;
            period    <= '0;
            high_time <= '0;
            wd        <= '0;
            fall_seen <= 1'b0;
          end
        end
        ARM: begin
          wd <= wd + CNT_W'(1);
          if (rise) begin
            cnt <= CNT_W'(1);
          end else if (wd_hit) begin
            timeout   <= 1'b1;
            period    <= '0;
            high_time <= '0;
          end
        end
        MEASURE: begin
          wd <= wd + CNT_W'(1);
          if (rise) begin
            period <= cnt;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (fall && !fall_seen) begin
              high_time <= cnt;
              fall_seen <= 1'b1;
            end
            // An abort discards any high time latched earlier in this cycle.
            if (wd_hit) begin
              timeout   <= 1'b1;
              period    <= '0;
              high_time <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter with CNT_W=8, TIMEOUT=64.
module tb_clk_period_meter;

  localparam int unsigned     CNT_W   = 8;
  localparam longint unsigned TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             sig_in;
  logic             start;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             timeout;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;

  // Stimulus generator state: constant level, square wave, or divide-by-3 toggle.
  bit          gen_const = 1'b1;
  bit          const_lvl = 1'b0;
  bit          gen_div   = 1'b0;
  bit          div_q     = 1'b0;
  int unsigned div_cnt   = 0;
  int unsigned gen_per   = 10;
  int unsigned gen_hi    = 4;
  int unsigned ph        = 1;

  clk_period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .start     (start),
    .busy      (busy),
    .valid     (valid),
    .period    (period),
    .high_time (high_time),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_const) begin
        sig_in = const_lvl;
      end else if (gen_div) begin
        sig_in = div_q;
        if (div_cnt == 2) begin
          div_cnt = 0;
          div_q   = ~div_q;
        end else begin
          div_cnt++;
        end
      end else begin
        sig_in = (ph < gen_hi);
        ph     = (ph + 1 == gen_per) ? 0 : ph + 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck, required finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d required %0d", tag, got, exp);
    end
  endtask

  task automatic set_square(input int unsigned p, input int unsigned h);
    gen_const = 1'b0;
    gen_div   = 1'b0;
    gen_per   = p;
    gen_hi    = h;
    ph        = 1;
    repeat (2 * p) @(negedge clk);
    #1;
  endtask

  task automatic wait_phase(input int unsigned k);
    for (int i = 0; i < 200; i++) begin
      if (ph == k) return;
      @(negedge clk);
      #1;
    end
    check_val("phase_wait", 0, 1);
  endtask

  task automatic pulse_start(input exp_t e, input bit push);
    start = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic collect(input string tag);
    bit   found;
    exp_t e;
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!found) check_val({tag, "_valid"}, 0, 1);
    if (exp_q.size() == 0) begin
      check_val({tag, "_scoreboard"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_period"},    period,    e.period);
      check_val({tag, "_high_time"}, high_time, e.high_time);
      check_val({tag, "_timeout"},   timeout,   e.timeout);
      check_val({tag, "_busy"},      busy,      0);
    end
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_busy",      busy,      0);
    check_val("rst_valid",     valid,     0);
    check_val("rst_timeout",   timeout,   0);
    check_val("rst_period",    period,    0);
    check_val("rst_high_time", high_time, 0);
    reset = 1'b0;

    // Square wave 10/4
    set_square(10, 4);
    wait_phase(0);
    pulse_start('{8'd10, 8'd4, 1'b0}, 1'b1);
    collect("sq10");

    // Divide-by-3 toggle: period 6, high 3
    gen_const = 1'b0;
    gen_div   = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    pulse_start('{8'd6, 8'd3, 1'b0}, 1'b1);
    collect("div3");

    // Stuck low: watchdog abort 65 cycles after start
    gen_div   = 1'b0;
    gen_const = 1'b1;
    const_lvl = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    start = 1'b1;
    exp_q.push_back('{8'd0, 8'd0, 1'b1});
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) start = 1'b0;
      if (valid) break;
    end
    check_val("tmo_latency", n, 65);
    collect("tmo");

    // Rise coinciding with the watchdog limit wins; one cycle later it aborts
    set_square(60, 25);
    wait_phase(0);
    pulse_start('{8'd60, 8'd25, 1'b0}, 1'b1);
    collect("wd_race_rise");
    set_square(61, 25);
    wait_phase(0);
    pulse_start('{8'd0, 8'd0, 1'b1}, 1'b1);
    collect("wd_race_abort");

    // Reset in the middle of MEASURE, then a clean measurement
    set_square(20, 8);
    wait_phase(0);
    pulse_start('{8'd0, 8'd0, 1'b0}, 1'b0);
    repeat (12) @(negedge clk);
    #1;
    check_val("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    check_val("mid_rst_busy",   busy,   0);
    check_val("mid_rst_valid",  valid,  0);
    check_val("mid_rst_period", period, 0);
    wait_phase(0);
    pulse_start('{8'd20, 8'd8, 1'b0}, 1'b1);
    collect("after_rst");

    // Start during ARM is ignored; start in DONE re-arms
    wait_phase(10);
    pulse_start('{8'd20, 8'd8, 1'b0}, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check_val("arm_busy", busy, 1);
    pulse_start('{8'd0, 8'd0, 1'b0}, 1'b0);
    collect("arm_start");
    pulse_start('{8'd20, 8'd8, 1'b0}, 1'b1);
    check_val("rearm_valid", valid, 0);
    check_val("rearm_busy",  busy,  1);
    collect("rearm");

    // sig_in already high at start must not count as an edge
    wait_phase(6);
    pulse_start('{8'd20, 8'd8, 1'b0}, 1'b1);
    collect("high_at_start");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
